// File: rtl/collision_event_sequencer_if.sv
// Bundle between the pixel priority mixer / frame timing and the game-event sequencer.
// The master side produces frame pulses, restart and the collision flags, and the
// slave side (the sequencer) returns the game-state outputs.
interface collision_event_sequencer_if;
  logic       start_of_frame;
  logic       restart;
  logic       collision_building_1;
  logic       collision_building_2;
  logic [2:0] collision_lightning;
  logic       collision_bird;
  logic       destructed_building_1;
  logic       destructed_building_2;
  logic [2:0] lightning_rearm;
  logic [1:0] lives;
  logic [7:0] score;
  logic       invulnerable;
  logic       game_over;

  modport master (
    output start_of_frame, restart,
    output collision_building_1, collision_building_2, collision_lightning, collision_bird,
    input  destructed_building_1, destructed_building_2, lightning_rearm,
    input  lives, score, invulnerable, game_over
  );

  modport slave (
    input  start_of_frame, restart,
    input  collision_building_1, collision_building_2, collision_lightning, collision_bird,
    output destructed_building_1, destructed_building_2, lightning_rearm,
    output lives, score, invulnerable, game_over
  );
endinterface

// File: rtl/collision_event_sequencer.sv
// Frame-rate game-event controller. Collision flags from the mixer are OR-accumulated
// across a frame; at each frame boundary the accumulated snapshot drives building
// destruction, lightning re-arm pulses, lives/invulnerability, score and game over.
module collision_event_sequencer #(
  parameter int LIVES_INIT      = 3,
  parameter int DESTRUCT_FRAMES = 30,
  parameter int INVULN_FRAMES   = 60
) (
  input  logic                          clk,
  input  logic                          resetN,
  collision_event_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {PLAY, COOLDOWN, GAME_OVER} state_t;

  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [7:0] DCNT_LOAD  = 8'(DESTRUCT_FRAMES);
  localparam logic [7:0] ICNT_LOAD  = 8'(INVULN_FRAMES);

  // Flag vector layout: {building_1, building_2, lightning[2:0], bird}
  logic [5:0]      cur;
  logic [5:0]      snap;
  logic            any_lightning;

  state_t          state_q, state_d;
  logic [5:0]      lat_q, lat_d;
  logic [1:0]      dest_q, dest_d;     // bit 0 = building 1, bit 1 = building 2
  logic [1:0][7:0] dcnt_q, dcnt_d;
  logic [7:0]      icnt_q, icnt_d;
  logic [2:0]      rearm_q, rearm_d;
  logic [1:0]      lives_q, lives_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      new_cnt;

  // Score increment that sticks at the 8-bit ceiling instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign cur = {bus.collision_building_1, bus.collision_building_2,
                bus.collision_lightning, bus.collision_bird};
  // A flag seen in the boundary cycle itself still belongs to the closing frame.
  assign snap          = lat_q | cur;
  assign any_lightning = |snap[3:1];

  // Frame latch, per-frame game actions and the PLAY/COOLDOWN/GAME_OVER transitions.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q | cur;
    dest_d  = dest_q;
    dcnt_d  = dcnt_q;
    icnt_d  = icnt_q;
    rearm_d = 3'b000;
    lives_d = lives_q;
    score_d = score_q;
    new_cnt = 2'd0;

    unique case (state_q)
      GAME_OVER: begin
        // Restart outranks a coincident frame boundary; that frame's snapshot is dropped.
        if (bus.restart) begin
          state_d = PLAY;
          lat_d   = '0;
          dest_d  = '0;
          dcnt_d  = '0;
          icnt_d  = '0;
          lives_d = LIVES_LOAD;
          score_d = 8'd0;
        end else if (bus.start_of_frame) begin
          lat_d = '0;
        end
      end
      default: begin
        if (bus.start_of_frame) begin
          lat_d   = '0;
          rearm_d = snap[3:1];
          for (int n = 0; n < 2; n++) begin
            if (dest_q[n]) begin
              // Re-hits during the destruction period neither restart nor score.
              dcnt_d[n] = dcnt_q[n] - 8'd1;
              if (dcnt_q[n] == 8'd1) dest_d[n] = 1'b0;
            end else if (snap[5-n] && any_lightning) begin
              dest_d[n] = 1'b1;
              dcnt_d[n] = DCNT_LOAD;
              new_cnt   = new_cnt + 2'd1;
            end
          end
          score_d = sat_add(score_q, new_cnt);

          if (state_q == COOLDOWN) begin
            icnt_d = icnt_q - 8'd1;
            if (icnt_q == 8'd1) state_d = PLAY;
          end else if (snap[0]) begin
            if (lives_q == 2'd1) begin
              lives_d = 2'd0;
              state_d = GAME_OVER;
            end else begin
              lives_d = lives_q - 2'd1;
              icnt_d  = ICNT_LOAD;
              state_d = COOLDOWN;
            end
          end
        end
      end
    endcase
  end

  // State and counter registers; reset discards any frame or countdown in progress.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= PLAY;
      lat_q   <= '0;
      dest_q  <= '0;
      dcnt_q  <= '0;
      icnt_q  <= '0;
      rearm_q <= '0;
      lives_q <= LIVES_LOAD;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      dest_q  <= dest_d;
      dcnt_q  <= dcnt_d;
      icnt_q  <= icnt_d;
      rearm_q <= rearm_d;
      lives_q <= lives_d;
      score_q <= score_d;
    end
  end

  assign bus.destructed_building_1 = dest_q[0];
  assign bus.destructed_building_2 = dest_q[1];
  assign bus.lightning_rearm       = rearm_q;
  assign bus.lives                 = lives_q;
  assign bus.score                 = score_q;
  assign bus.invulnerable          = (state_q == COOLDOWN);
  assign bus.game_over             = (state_q == GAME_OVER);

endmodule

// File: tb/tb_collision_event_sequencer.sv
// Bench for collision_event_sequencer: directed frame sequences, a frame-level game
// model compared every cycle, and hand-computed expectations at key points.
module tb_collision_event_sequencer;
  localparam int LIVES_INIT = 3;
  localparam int DF         = 30;
  localparam int IFR        = 60;
  localparam int M_PLAY = 0, M_COOL = 1, M_OVER = 2;

  logic clk    = 1'b0;
  logic resetN = 1'b1;
  always #5 clk = ~clk;

  collision_event_sequencer_if bus();

  collision_event_sequencer #(
    .LIVES_INIT(LIVES_INIT), .DESTRUCT_FRAMES(DF), .INVULN_FRAMES(IFR)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Game model: what the outputs must show after each clock edge.
  int         m_lives  = LIVES_INIT;
  int         m_score  = 0;
  int         m_mode   = M_PLAY;
  int         m_ileft  = 0;
  logic [5:0] m_seen   = '0;
  logic [2:0] m_rearm  = '0;
  logic       m_dest[2] = '{1'b0, 1'b0};
  int         m_left[2] = '{0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_lives = LIVES_INIT; m_score = 0; m_mode = M_PLAY; m_ileft = 0;
    m_seen = '0; m_rearm = '0;
    m_dest[0] = 1'b0; m_dest[1] = 1'b0; m_left[0] = 0; m_left[1] = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    logic [5:0] now, frame;
    int gained;
    now = {bus.collision_building_1, bus.collision_building_2,
           bus.collision_lightning, bus.collision_bird};
    m_rearm = 3'b000;
    if (!resetN) begin
      model_reset();
    end else if (m_mode == M_OVER) begin
      if (bus.restart) model_reset();
      else if (bus.start_of_frame) m_seen = '0;
      else m_seen = m_seen | now;
    end else if (!bus.start_of_frame) begin
      m_seen = m_seen | now;
    end else begin
      frame  = m_seen | now;
      m_seen = '0;
      gained = 0;
      for (int b = 0; b < 2; b++) begin
        if (m_dest[b]) begin
          m_left[b] = m_left[b] - 1;
          if (m_left[b] == 0) m_dest[b] = 1'b0;
        end else if (frame[5-b] && frame[3:1] != 3'b000) begin
          m_dest[b] = 1'b1;
          m_left[b] = DF;
          gained++;
        end
      end
      m_score = (m_score + gained > 255) ? 255 : m_score + gained;
      m_rearm = frame[3:1];
      if (m_mode == M_COOL) begin
        m_ileft = m_ileft - 1;
        if (m_ileft == 0) m_mode = M_PLAY;
      end else if (frame[0]) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_mode = M_OVER;
        else begin m_mode = M_COOL; m_ileft = IFR; end
      end
    end
  endtask

  // Every-cycle comparison against the model (or against reset values while in reset).
  always @(negedge clk) begin
    if (!resetN) begin
      chk("rst_lives", int'(bus.lives), LIVES_INIT);
      chk("rst_score", int'(bus.score), 0);
      chk("rst_dest",  int'({bus.destructed_building_1, bus.destructed_building_2}), 0);
      chk("rst_flags", int'({bus.invulnerable, bus.game_over, bus.lightning_rearm}), 0);
    end else begin
      chk("lives", int'(bus.lives), m_lives);
      chk("score", int'(bus.score), m_score);
      chk("dest1", int'(bus.destructed_building_1), int'(m_dest[0]));
      chk("dest2", int'(bus.destructed_building_2), int'(m_dest[1]));
      chk("rearm", int'(bus.lightning_rearm), int'(m_rearm));
      chk("invuln", int'(bus.invulnerable), (m_mode == M_COOL) ? 1 : 0);
      chk("game_over", int'(bus.game_over), (m_mode == M_OVER) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_flags(input logic b1, input logic b2, input logic [2:0] lt, input logic bird);
    bus.collision_building_1 = b1;
    bus.collision_building_2 = b2;
    bus.collision_lightning  = lt;
    bus.collision_bird       = bird;
  endtask

  task automatic sof_pulse();
    bus.start_of_frame = 1'b1;
    tick();
    bus.start_of_frame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof_pulse();
      tick();
    end
  endtask

  initial begin
    bus.start_of_frame = 1'b0;
    bus.restart        = 1'b0;
    set_flags(1'b0, 1'b0, 3'b000, 1'b0);
    #1 resetN = 1'b0;
    tick(); tick();
    chk("init_lives", int'(bus.lives), 3);
    chk("init_score", int'(bus.score), 0);
    resetN = 1'b1;
    tick();

    // 1: empty frame
    sof_pulse();
    chk("t1_lives", int'(bus.lives), 3);
    chk("t1_score", int'(bus.score), 0);
    chk("t1_go", int'(bus.game_over), 0);

    // 2: building 1 + lightning 2 held 10 clocks mid-frame, then the boundary
    set_flags(1'b1, 1'b0, 3'b010, 1'b0);
    repeat (10) tick();
    set_flags(1'b0, 1'b0, 3'b000, 1'b0);
    tick(); tick();
    chk("t2_pre_dest1", int'(bus.destructed_building_1), 0);
    sof_pulse();
    chk("t2_dest1", int'(bus.destructed_building_1), 1);
    chk("t2_score", int'(bus.score), 1);
    chk("t2_rearm", int'(bus.lightning_rearm), 3'b010);
    tick();
    chk("t2_rearm_off", int'(bus.lightning_rearm), 0);
    frames(29);
    chk("t2_dest1_29", int'(bus.destructed_building_1), 1);
    frames(1);
    chk("t2_dest1_30", int'(bus.destructed_building_1), 0);

    // 3: re-hit during destruction, then both buildings in one frame
    set_flags(1'b1, 1'b0, 3'b100, 1'b0);
    sof_pulse();
    set_flags(1'b0, 1'b0, 3'b000, 1'b0);
    chk("t3_score_a", int'(bus.score), 2);
    frames(10);
    set_flags(1'b1, 1'b0, 3'b001, 1'b0);
    sof_pulse();
    set_flags(1'b0, 1'b0, 3'b000, 1'b0);
    chk("t3_rehit_score", int'(bus.score), 2);
    frames(18);
    chk("t3_dest1_29", int'(bus.destructed_building_1), 1);
    frames(1);
    chk("t3_dest1_30", int'(bus.destructed_building_1), 0);
    set_flags(1'b1, 1'b1, 3'b001, 1'b0);
    sof_pulse();
    set_flags(1'b0, 1'b0, 3'b000, 1'b0);
    chk("t3_both_score", int'(bus.score), 4);
    chk("t3_both_dest2", int'(bus.destructed_building_2), 1);

    // 4: bird hit, cooldown ignores bird, then another hit
    set_flags(1'b0, 1'b0, 3'b000, 1'b1);
    tick();
    set_flags(1'b0, 1'b0, 3'b000, 1'b0);
    sof_pulse();
    chk("t4_lives", int'(bus.lives), 2);
    chk("t4_inv", int'(bus.invulnerable), 1);
    for (int i = 0; i < 59; i++) begin
      bus.collision_bird = 1'b1;
      sof_pulse();
      bus.collision_bird = 1'b0;
      tick();
    end
    chk("t4_cool_lives", int'(bus.lives), 2);
    chk("t4_cool_inv", int'(bus.invulnerable), 1);
    bus.collision_bird = 1'b1;
    sof_pulse();
    bus.collision_bird = 1'b0;
    chk("t4_end_inv", int'(bus.invulnerable), 0);
    chk("t4_end_lives", int'(bus.lives), 2);
    bus.collision_bird = 1'b1;
    sof_pulse();
    bus.collision_bird = 1'b0;
    chk("t4_lives1", int'(bus.lives), 1);

    // 5: final life lost alongside a building hit, frozen game over, restart
    frames(60);
    chk("t5_inv_off", int'(bus.invulnerable), 0);
    set_flags(1'b1, 1'b0, 3'b010, 1'b1);
    sof_pulse();
    chk("t5_lives", int'(bus.lives), 0);
    chk("t5_go", int'(bus.game_over), 1);
    chk("t5_score", int'(bus.score), 5);
    chk("t5_rearm", int'(bus.lightning_rearm), 3'b010);
    set_flags(1'b0, 1'b1, 3'b111, 1'b1);
    frames(40);
    chk("t5_frz_score", int'(bus.score), 5);
    chk("t5_frz_dest1", int'(bus.destructed_building_1), 1);
    chk("t5_frz_dest2", int'(bus.destructed_building_2), 0);
    bus.restart = 1'b1;
    bus.start_of_frame = 1'b1;
    tick();
    bus.restart = 1'b0;
    bus.start_of_frame = 1'b0;
    set_flags(1'b0, 1'b0, 3'b000, 1'b0);
    chk("t5_rs_lives", int'(bus.lives), 3);
    chk("t5_rs_score", int'(bus.score), 0);
    chk("t5_rs_go", int'(bus.game_over), 0);
    chk("t5_rs_dest1", int'(bus.destructed_building_1), 0);
    sof_pulse();
    chk("t5_post_score", int'(bus.score), 0);
    chk("t5_post_rearm", int'(bus.lightning_rearm), 0);
    set_flags(1'b1, 1'b0, 3'b001, 1'b0);
    sof_pulse();
    set_flags(1'b0, 1'b0, 3'b000, 1'b0);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    tick();
    chk("t5_play_rs_score", int'(bus.score), 1);
    chk("t5_play_rs_dest1", int'(bus.destructed_building_1), 1);

    // 6: saturation, then asynchronous reset in the middle of a cooldown
    set_flags(1'b1, 1'b1, 3'b001, 1'b0);
    bus.start_of_frame = 1'b1;
    repeat (4300) tick();
    bus.start_of_frame = 1'b0;
    set_flags(1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    chk("t6_sat", int'(bus.score), 255);
    bus.collision_bird = 1'b1;
    sof_pulse();
    bus.collision_bird = 1'b0;
    chk("t6_cool", int'(bus.invulnerable), 1);
    frames(3);
    #2 resetN = 1'b0;
    #1;
    chk("t6_rst_lives", int'(bus.lives), 3);
    chk("t6_rst_score", int'(bus.score), 0);
    chk("t6_rst_inv", int'(bus.invulnerable), 0);
    chk("t6_rst_dest", int'({bus.destructed_building_1, bus.destructed_building_2}), 0);
    tick(); tick();
    resetN = 1'b1;
    tick();
    sof_pulse();
    chk("t6_after_score", int'(bus.score), 0);
    chk("t6_after_lives", int'(bus.lives), 3);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
